// File: rtl/input_debounce_pkg.sv
// Shared constants and sizing helpers for the input debouncer.
package input_debounce_pkg;

   localparam int TICK_HZ = 1000;

   function automatic int tick_div(input int clk_hz);
      return clk_hz / TICK_HZ;
   endfunction

   // Counter must hold 0..ms-1; ms+1 keeps a 1-bit minimum for ms = 1.
   function automatic int cnt_width(input int ms);
      return (ms < 1) ? 1 : $clog2(ms + 1);
   endfunction

endpackage

// File: rtl/input_debounce_channel.sv
// One debounce channel: 2-flop synchroniser, tick-counted hold filter, optional edge pulses.
// Latency 2 + DEBOUNCE_MS ticks worst case; no backpressure, outputs registered.
module debounce_channel
   import input_debounce_pkg::*;
#(
   parameter int DEBOUNCE_MS = 10
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic din,
   input  logic tick,
   output logic dout,
   output logic rise,
   output logic fall
);

   localparam int CW = cnt_width(DEBOUNCE_MS);

   logic          meta;
   logic          s;
   logic [CW-1:0] cnt;
   logic          accept;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         meta <= 1'b0;
         s    <= 1'b0;
      end else begin
         meta <= din;
         s    <= meta;
      end
   end

   assign accept = (s != dout) && tick && (cnt == CW'(DEBOUNCE_MS - 1));

   // Any cycle where s agrees with dout cancels a pending change.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         cnt  <= '0;
         dout <= 1'b0;
      end else if (s == dout) begin
         cnt <= '0;
      end else if (accept) begin
         cnt  <= '0;
         dout <= s;
      end else if (tick) begin
         cnt <= cnt + CW'(1);
      end
   end

`ifdef INPUT_DEBOUNCE_EDGE_EN
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         rise <= accept & s;
         fall <= accept & ~s;
      end
   end
`else
   assign rise = 1'b0;
   assign fall = 1'b0;
`endif

endmodule

// File: rtl/input_debounce.sv
// N-channel input debouncer with a shared 1 ms prescaler; RISE/FALL built only with INPUT_DEBOUNCE_EDGE_EN.
// Latency 2 + (DEBOUNCE_MS-1)*TICK_DIV + 1 .. 2 + DEBOUNCE_MS*TICK_DIV edges; no backpressure.
module input_debounce
   import input_debounce_pkg::*;
#(
   parameter int N           = 20,
   parameter int CLK_HZ      = 10_000_000,
   parameter int DEBOUNCE_MS = 10
) (
   input  logic         CLK,
   input  logic         RST_N,
   input  logic [N-1:0] DIN,
   output logic [N-1:0] DOUT,
   output logic [N-1:0] RISE,
   output logic [N-1:0] FALL
);

   localparam int TICK_DIV = tick_div(CLK_HZ);
   localparam int PW       = $clog2(TICK_DIV);

   logic [PW-1:0] presc;
   logic          tick;

   assign tick = (presc == PW'(TICK_DIV - 1));

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         presc <= '0;
      end else if (tick) begin
         presc <= '0;
      end else begin
         presc <= presc + PW'(1);
      end
   end

   for (genvar g = 0; g < N; g++) begin : g_ch
      debounce_channel #(
         .DEBOUNCE_MS (DEBOUNCE_MS)
      ) u_ch (
         .CLK   (CLK),
         .RST_N (RST_N),
         .din   (DIN[g]),
         .tick  (tick),
         .dout  (DOUT[g]),
         .rise  (RISE[g]),
         .fall  (FALL[g])
      );
   end

endmodule

// File: tb/tb_input_debounce.sv
// Directed scenarios plus randomized bouncing, checked every cycle against a tick-counting reference model.
module tb_input_debounce;

   localparam int N    = 8;
   localparam int CLKH = 10000;
   localparam int MS   = 3;
   localparam int TDIV = CLKH / 1000;

   logic         CLK = 1'b0;
   logic         RST_N = 1'b0;
   logic [N-1:0] DIN = '0;
   logic [N-1:0] DOUT, RISE, FALL;

   input_debounce #(.N(N), .CLK_HZ(CLKH), .DEBOUNCE_MS(MS)) dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .DIN   (DIN),
      .DOUT  (DOUT),
      .RISE  (RISE),
      .FALL  (FALL)
   );

   always #5 CLK = ~CLK;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state
   logic [N-1:0] hist[$];
   logic [N-1:0] m_dout = '0, m_rise = '0, m_fall = '0;
   bit           run_on[N];
   int           run_start[N];
   int           ecnt = 0;

   // DUT observation
   int           tb_cyc = 0;
   logic [N-1:0] prev_dout = '0;
   int           n_up[N], n_dn[N], up_cyc[N], dn_cyc[N];
   logic [N-1:0] cur_din = '0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         if (n_fail <= 30)
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, tb_cyc, got, exp);
      end
   endtask

   task automatic model_reset();
      hist.delete();
      m_dout = '0; m_rise = '0; m_fall = '0;
      ecnt = 0;
      for (int i = 0; i < N; i++) run_on[i] = 0;
   endtask

   // Edge c sees the input sampled two edges earlier; ticks land on edges with c % TDIV == TDIV-1.
   // A change is accepted on the edge completing MS ticks of uninterrupted disagreement.
   task automatic model_edge();
      logic [N-1:0] s;
      s = (hist.size() == 2) ? hist[0] : '0;
      hist.push_back(DIN);
      if (hist.size() > 2) void'(hist.pop_front());
      m_rise = '0;
      m_fall = '0;
      for (int i = 0; i < N; i++) begin
         if (s[i] == m_dout[i]) begin
            run_on[i] = 0;
         end else begin
            if (!run_on[i]) begin
               run_on[i]    = 1;
               run_start[i] = ecnt;
            end
            if ((ecnt + 1) / TDIV - run_start[i] / TDIV == MS) begin
               m_dout[i] = s[i];
               if (s[i]) m_rise[i] = 1'b1;
               else      m_fall[i] = 1'b1;
               run_on[i] = 0;
            end
         end
      end
      ecnt++;
   endtask

   // Called at a negedge: drive, clock once, check at the following negedge.
   task automatic step(input logic [N-1:0] din, input logic rst_n);
      logic [N-1:0] er, ef;
      DIN   = din;
      RST_N = rst_n;
      if (!rst_n) model_reset();
      @(posedge CLK);
      if (rst_n) model_edge();
      @(negedge CLK);
      tb_cyc++;
`ifdef INPUT_DEBOUNCE_EDGE_EN
      er = m_rise;
      ef = m_fall;
`else
      er = '0;
      ef = '0;
`endif
      chk("dout", 32'(DOUT), 32'(m_dout));
      chk("rise", 32'(RISE), 32'(er));
      chk("fall", 32'(FALL), 32'(ef));
      for (int i = 0; i < N; i++) begin
         if (DOUT[i] && !prev_dout[i]) begin n_up[i]++; up_cyc[i] = tb_cyc; end
         if (!DOUT[i] && prev_dout[i]) begin n_dn[i]++; dn_cyc[i] = tb_cyc; end
      end
      prev_dout = DOUT;
   endtask

   task automatic run(input int cycles);
      for (int k = 0; k < cycles; k++) step(cur_din, 1'b1);
   endtask

   // Counts edges from the current drive until DOUT[ch] is observed high; 999 if it never happens.
   task automatic wait_up(input int ch, output int lat);
      lat = 999;
      for (int k = 1; k <= 60; k++) begin
         step(cur_din, 1'b1);
         if (DOUT[ch]) begin
            lat = k;
            break;
         end
      end
   endtask

   initial begin
      int lat;
      int up0, dn0;
      int bounce_left[N];
      logic [N-1:0] target;

      for (int i = 0; i < N; i++) begin
         n_up[i] = 0; n_dn[i] = 0; up_cyc[i] = -1; dn_cyc[i] = -2; bounce_left[i] = 0;
      end
      @(negedge CLK);

      // reset state
      for (int k = 0; k < 3; k++) step('0, 1'b0);
      chk("rst_dout", 32'(DOUT), 32'h0);
      chk("rst_rise", 32'(RISE), 32'h0);
      chk("rst_fall", 32'(FALL), 32'h0);

      // clean step
      run(7);
      cur_din[0] = 1'b1;
      wait_up(0, lat);
      chk("clean_lat_window", 32'(lat >= 23 && lat <= 32), 32'h1);
      chk("clean_others", 32'(DOUT[N-1:1]), 32'h0);
      run(10);
      chk("clean_one_up", 32'(n_up[0]), 32'h1);

      // glitch rejection
      cur_din[1] = 1'b1;
      run(15);
      cur_din[1] = 1'b0;
      run(50);
      chk("glitch_no_up", 32'(n_up[1]), 32'h0);

      // bounce then hold
      for (int k = 0; k < 10; k++) begin
         cur_din[2] = ~cur_din[2];
         run(4);
      end
      cur_din[2] = 1'b1;
      run(45);
      chk("bounce_one_up", 32'(n_up[2]), 32'h1);
      chk("bounce_dout", 32'(DOUT[2]), 32'h1);
      chk("bounce_no_dn", 32'(n_dn[2]), 32'h0);

      // release and independence
      cur_din[2] = 1'b0;
      cur_din[5] = 1'b1;
      run(45);
      chk("indep_dn2", 32'(n_dn[2]), 32'h1);
      chk("indep_up5", 32'(n_up[5]), 32'h1);
      chk("indep_same_edge", 32'(dn_cyc[2] == up_cyc[5]), 32'h1);

      // reset mid-count
      cur_din[3] = 1'b1;
      run(2 * TDIV);
      for (int k = 0; k < 3; k++) begin
         step(cur_din, 1'b0);
         chk("midrst_dout", 32'(DOUT), 32'h0);
         chk("midrst_edges", 32'(RISE | FALL), 32'h0);
      end
      prev_dout = '0;
      up0 = n_up[3];
      wait_up(3, lat);
      chk("midrst_lat_window", 32'(lat >= 23 && lat <= 32), 32'h1);
      chk("midrst_one_up", 32'(n_up[3] - up0), 32'h1);

      // randomized bouncing on all channels
      target = cur_din;
      dn0 = 0;
      for (int k = 0; k < 2500; k++) begin
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 59) == 0) begin
               target[i]      = ~target[i];
               bounce_left[i] = $urandom_range(0, 14);
            end
            if (bounce_left[i] > 0) begin
               bounce_left[i]--;
               cur_din[i] = 1'($urandom_range(0, 1));
            end else begin
               cur_din[i] = target[i];
            end
         end
         step(cur_din, 1'b1);
         if (k % 400 == 399 && $urandom_range(0, 1) == 1) begin
            step(cur_din, 1'b0);
            prev_dout = '0;
            dn0++;
         end
      end
      cur_din = target;
      run(50);
      chk("rand_settled", 32'(DOUT), 32'(target));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
